// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Synchronous FIFO of fetched {pc, instr} entries; flush wins.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = pop & (r_count != '0);
  assign w_push = push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch PC owner; one outstanding imem request, queued delivery.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] startPC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  fetch_state_t      r_state, w_state_nxt;
  logic              r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_start_pc, w_redirect_pc, w_pc_plus;
  logic              w_push, w_pop, w_empty;
  logic              w_idle_room, w_wait_room;
  logic [CNT_W-1:0]  w_count;
  fetch_entry_t      w_din, w_dout;
  logic              w_unused_bits;

  assign w_start_pc    = {startPC[ADDR_W-1:2], 2'b00};
  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_pc_plus     = r_fetch_pc + ADDR_W'(INSTR_BYTES);
  assign w_unused_bits = ^{startPC[1:0], redirect_pc[1:0]};

  assign w_pop = ~w_empty & instr_ready;
  assign w_din = '{pc: r_fetch_pc, instr: imem_rdata};

  // Room checks use the post-cycle count so the new request always owns a free slot.
  assign w_idle_room = (w_count - CNT_W'(w_pop)) < c_depth;
  assign w_wait_room = (w_count - CNT_W'(w_pop) + CNT_W'(1)) < c_depth;

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          w_req_nxt      = 1'b1;
          w_addr_nxt     = w_redirect_pc;
          w_state_nxt    = WAIT;
        end else if (w_idle_room) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          w_fetch_pc_nxt = w_redirect_pc;
          if (imem_ack) w_addr_nxt  = w_redirect_pc;
          else          w_state_nxt = DISCARD;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_pc_plus;
          w_addr_nxt     = w_pc_plus;
          if (!w_wait_room) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        // The stale request stays on the bus until memory answers it.
        if (redirect) w_fetch_pc_nxt = w_redirect_pc;
        if (imem_ack) begin
          w_addr_nxt  = w_fetch_pc_nxt;
          w_state_nxt = WAIT;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= w_start_pc;
      r_fetch_pc <= w_start_pc;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = ~w_empty;
  assign instr_out   = w_dout.instr;
  assign instr_pc    = w_dout.pc;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end sitting directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake, tolerating wait-states.
- Buffers returned words with their PCs in a small queue, and presents them to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from the datapath and flushes any stale instructions.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, >=2).
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- startPC  input  32  PC loaded while reset is high.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word address of request; low 2 bits always 0.
- imem_ack  input  1  memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  queue head valid.
- instr_out  output  32  queue head instruction.
- instr_pc  output  32  PC of queue head.
- instr_ready  input  1  decode accepts head when instr_valid and instr_ready are both high.
- redirect  input  1  load new fetch PC and flush.
- redirect_pc  input  32  target PC; bits [1:0] ignored (forced 0).

Behaviour:
- Reset values, applied while reset is high:
  - fetch_pc = {startPC[31:2],2'b00}.
  - Queue empty: instr_valid=0, instr_out=0, instr_pc=0.
  - imem_req=0, imem_addr=fetch_pc, state=IDLE.
  - imem_ack is ignored while reset is high.
- At most one outstanding request. imem_req and imem_addr are registered and held stable from assertion until the ack cycle.
- States:
  - IDLE: if count + 0 < DEPTH, assert imem_req at fetch_pc and go to WAIT.
  - WAIT: on imem_ack, push {fetch_pc, imem_rdata} and set fetch_pc += 4. If a slot is still free after this cycle's push/pop, keep imem_req high with the new address (back-to-back requests); otherwise drop imem_req and go to IDLE.
  - DISCARD: waiting for the ack of a request made stale by a redirect. imem_req stays high at the old address until ack. On ack, drop the data and issue at fetch_pc next cycle (go to WAIT).
- Ack latency: zero-wait memory (ack in the same cycle as req) gives sustained throughput of one instruction per cycle. The first instr_valid appears 2 cycles after reset deasserts.
- Slot reservation: a request issues only if count plus the outstanding request is <= DEPTH. A push therefore never hits a full queue; overflow is impossible by construction.
- Pop on instr_valid & instr_ready. Simultaneous push and pop leaves count unchanged.
- PC arithmetic is modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000, with no flag.
- Redirect, which has priority over everything except reset:
  - Queue is flushed (instr_valid=0 next cycle).
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - A head handshake in the same cycle counts as consumed.
  - If a request is outstanding and imem_ack is low: go to DISCARD.
  - If imem_ack is high in the same cycle: drop the data, issue at redirect_pc next cycle.
  - If no request is outstanding: issue at redirect_pc next cycle.
  - Redirect during DISCARD updates fetch_pc only; the unit stays in DISCARD.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight ack is discarded.
- instr_out and instr_pc are undefined-but-stable when instr_valid=0; the implementation drives them from the head slot.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DISCARD}.
  - INSTR_BYTES=4.
  - Queue entry struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_queue: synchronous FIFO of DEPTH entries.
  - Ports: push, pop, flush, din, dout, count, empty.
  - flush takes priority over push and pop.

Test Plan:
- Reset with startPC=0x40, zero-wait memory, instr_ready=1 -> imem_addr 0x40,0x44,0x48 on consecutive cycles; instr_valid high from cycle 2 with instr_pc 0x40,0x44,0x48 in order.
- instr_ready=0 with DEPTH=2 -> exactly 2 acks accepted and imem_req low thereafter. Then raise instr_ready -> instr_pc 0x40 then 0x44, and fetching resumes at 0x48.
- Ack delayed 3 cycles; redirect to 0x100 in cycle 1 of the wait -> the old-address word is never presented, the next imem_addr is 0x100, and the first instr_pc after the redirect is 0x100.
- Redirect to 0x200 coincident with imem_ack -> acked word dropped, imem_addr=0x200 on the next cycle, queue empty for that cycle.
- startPC=0xFFFFFFF8, zero-wait -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset asserted for 1 cycle while queue holds 2 entries and a request is outstanding with startPC=0x80 -> next cycle instr_valid=0 and imem_req=0. A late ack is ignored, then fetching restarts at 0x80.
